// File: rtl/stim_player_if.sv
// Script-entry handshake and driven-bus bundle for stim_player.
interface stim_player_if #(
  parameter int W     = 3,
  parameter int DLY_W = 16,
  parameter int TS_W  = 32
);
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [DLY_W-1:0] in_delay;
  logic [W-1:0]     in_value;
  logic [W-1:0]     in_oe;
  logic [W-1:0]     sig_out;
  logic [W-1:0]     sig_oe;
  logic             apply;
  logic             changed;
  logic [TS_W-1:0]  upd_ts;
  logic             busy;

  // script source / observer side
  modport master (
    output enable, in_valid, in_delay, in_value, in_oe,
    input  in_ready, sig_out, sig_oe, apply, changed, upd_ts, busy
  );

  // player side
  modport slave (
    input  enable, in_valid, in_delay, in_value, in_oe,
    output in_ready, sig_out, sig_oe, apply, changed, upd_ts, busy
  );
endinterface

// File: rtl/stim_player.sv
// Plays a queued {delay, value, oe} script onto a small bus and timestamps
// every applied entry.
module stim_player #(
  parameter int W     = 3,
  parameter int DLY_W = 16,
  parameter int DEPTH = 4,
  parameter int TS_W  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  stim_player_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [DLY_W-1:0] dly;
    logic [W-1:0]     val;
    logic [W-1:0]     oe;
  } entry_t;

  typedef enum logic {IDLE, WAIT} state_t;

  entry_t           r_mem [DEPTH];
  logic [PW:0]      r_wp, r_rp;
  state_t           r_state, w_nxt;
  logic [DLY_W-1:0] r_cnt;
  logic [W-1:0]     r_hold_val, r_hold_oe;
  logic [W-1:0]     r_sig_out, r_sig_oe;
  logic             r_apply, r_changed;
  logic [TS_W-1:0]  r_ts, r_upd_ts;

  logic   w_empty, w_full, w_push, w_pop, w_fire;
  entry_t w_head, w_in;
  logic [W-1:0] w_new_out;

  assign w_empty   = (r_wp == r_rp);
  assign w_full    = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_push    = bus.in_valid && !w_full;
  assign w_head    = r_mem[r_rp[PW-1:0]];
  assign w_in      = '{dly: bus.in_delay, val: bus.in_value, oe: bus.in_oe};
  // released bits are always driven as 0 underneath the oe mask
  assign w_new_out = r_hold_val & r_hold_oe;

  // next-state, pop and apply decisions; everything frozen while enable=0
  always_comb begin
    w_nxt  = r_state;
    w_pop  = 1'b0;
    w_fire = 1'b0;
    if (bus.enable) begin
      case (r_state)
        IDLE: if (!w_empty) begin
          w_pop = 1'b1;
          w_nxt = WAIT;
        end
        WAIT: if (r_cnt == '0) begin
          w_fire = 1'b1;
          if (!w_empty) w_pop = 1'b1;
          else          w_nxt = IDLE;
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // FIFO storage (no reset: contents are qualified by the pointers)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[PW-1:0]] <= w_in;
  end

  // FIFO pointers; extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // hold registers and delay countdown for the in-flight entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_hold_val <= '0;
      r_hold_oe  <= '0;
    end else if (w_pop) begin
      r_cnt      <= w_head.dly;
      r_hold_val <= w_head.val;
      r_hold_oe  <= w_head.oe;
    end else if (bus.enable && r_state == WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // drive the bus and emit the apply/changed pulses with a timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_out <= '0;
      r_sig_oe  <= '0;
      r_apply   <= 1'b0;
      r_changed <= 1'b0;
      r_upd_ts  <= '0;
    end else begin
      r_apply   <= w_fire;
      r_changed <= w_fire && ({r_hold_oe, w_new_out} != {r_sig_oe, r_sig_out});
      if (w_fire) begin
        r_sig_out <= w_new_out;
        r_sig_oe  <= r_hold_oe;
        r_upd_ts  <= r_ts;
      end
    end
  end

  // free-running timestamp, paused with enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_ts <= '0;
    else if (bus.enable) r_ts <= r_ts + 1'b1;
  end

  assign bus.in_ready = !w_full;
  assign bus.sig_out  = r_sig_out;
  assign bus.sig_oe   = r_sig_oe;
  assign bus.apply    = r_apply;
  assign bus.changed  = r_changed;
  assign bus.upd_ts   = r_upd_ts;
  assign bus.busy     = (r_state == WAIT) || !w_empty;
endmodule

// File: tb/tb_stim_player.sv
// Randomized and directed bench for stim_player against an event-time model:
// an entry popped when the (enabled-cycle) timestamp is m applies when the
// timestamp reaches m+D+1.
module tb_stim_player;
  localparam int W = 3, DLY_W = 16, DEPTH = 4, TS_W = 32;

  typedef struct {
    int unsigned dly;
    logic [W-1:0] val;
    logic [W-1:0] oe;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stim_player_if #(.W(W), .DLY_W(DLY_W), .TS_W(TS_W)) bus ();

  stim_player #(.W(W), .DLY_W(DLY_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int errors = 0, checks = 0;
  int n_apply = 0, n_chg = 0;

  // reference model state
  ent_t         q[$];
  ent_t         cur;
  bit           inflight;
  longint       due, m_ts;
  logic [W-1:0] m_out, m_oe;
  logic         m_apply, m_changed;
  logic [TS_W-1:0] m_upd;
  logic [W-1:0] order_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    inflight = 0; due = 0; m_ts = 0;
    m_out = '0; m_oe = '0; m_apply = 0; m_changed = 0; m_upd = '0;
  endtask

  task automatic check_all();
    chk("sig_out",  bus.sig_out,  m_out);
    chk("sig_oe",   bus.sig_oe,   m_oe);
    chk("apply",    bus.apply,    m_apply);
    chk("changed",  bus.changed,  m_changed);
    chk("upd_ts",   bus.upd_ts,   m_upd);
    chk("busy",     bus.busy,     inflight || (q.size() > 0));
    chk("in_ready", bus.in_ready, q.size() < DEPTH);
  endtask

  // one clock: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    bit   pushed;
    ent_t e;
    @(posedge clk);
    pushed = bus.in_valid && (q.size() < DEPTH);
    e.dly = bus.in_delay; e.val = bus.in_value; e.oe = bus.in_oe;
    m_apply = 0; m_changed = 0;
    if (bus.enable) begin
      if (inflight && m_ts == due) begin
        m_apply   = 1;
        m_changed = ({cur.oe, cur.val & cur.oe} != {m_oe, m_out});
        m_out     = cur.val & cur.oe;
        m_oe      = cur.oe;
        m_upd     = m_ts[TS_W-1:0];
        inflight  = 0;
      end
      if (!inflight && q.size() > 0) begin
        cur      = q.pop_front();
        inflight = 1;
        due      = m_ts + cur.dly + 1;
      end
      m_ts++;
    end
    if (pushed) q.push_back(e);
    #1;
    if (bus.apply)   begin n_apply++; order_q.push_back(bus.sig_out); end
    if (bus.changed) n_chg++;
    check_all();
  endtask

  task automatic push(input int unsigned d, input logic [W-1:0] v, input logic [W-1:0] oe);
    bus.in_valid = 1'b1; bus.in_delay = d[DLY_W-1:0]; bus.in_value = v; bus.in_oe = oe;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_idle(input int max);
    int k = 0;
    while (bus.busy && k < max) begin step(); k++; end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_delay = '0;
    bus.in_value = '0; bus.in_oe = '0;
    model_reset();

    // reset state
    do_reset();
    bus.enable = 1'b1;
    run(3);

    // single entry, long delay
    n_apply = 0; n_chg = 0;
    push(100, 3'b010, 3'b111);
    run_idle(300);
    chk("t2_applies", n_apply, 1);
    chk("t2_changed", n_chg, 1);
    chk("t2_out", bus.sig_out, 3'b010);

    // three-entry script, last one only changes oe
    n_apply = 0; n_chg = 0;
    push(100, 3'b010, 3'b111);
    push(100, 3'b100, 3'b111);
    push(0,   3'b100, 3'b011);
    run_idle(400);
    chk("t3_applies", n_apply, 3);
    chk("t3_changed", n_chg, 2);
    chk("t3_out", bus.sig_out, 3'b000);
    chk("t3_oe",  bus.sig_oe,  3'b011);

    // identical entries: two applies, one change
    n_apply = 0; n_chg = 0;
    push(5, 3'b111, 3'b111);
    push(5, 3'b111, 3'b111);
    run_idle(100);
    chk("t4_applies", n_apply, 2);
    chk("t4_changed", n_chg, 1);

    // fill while frozen; fifth push must be dropped
    n_apply = 0; order_q.delete();
    bus.enable = 1'b0;
    push(2, 3'b001, 3'b111);
    push(0, 3'b010, 3'b111);
    push(1, 3'b011, 3'b111);
    push(0, 3'b100, 3'b111);
    chk("t5_full", bus.in_ready, 1'b0);
    push(0, 3'b101, 3'b111);
    run(3);
    chk("t5_frozen", n_apply, 0);
    bus.enable = 1'b1;
    step();
    chk("t5_ready_after_pop", bus.in_ready, 1'b1);
    run_idle(100);
    chk("t5_applies", n_apply, 4);
    if (order_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t5_order", order_q[i], i + 1);
    end else chk("t5_order_len", order_q.size(), 4);

    // pause during countdown
    n_apply = 0;
    push(20, 3'b110, 3'b101);
    run(5);
    bus.enable = 1'b0;
    run(10);
    bus.enable = 1'b1;
    run_idle(100);
    chk("t6_applies", n_apply, 1);

    // random script
    for (int i = 0; i < 400; i++) begin
      bus.enable   = ($urandom_range(0, 7) != 0);
      bus.in_valid = $urandom_range(0, 1);
      bus.in_delay = DLY_W'($urandom_range(0, 6));
      bus.in_value = W'($urandom);
      bus.in_oe    = W'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    bus.enable   = 1'b1;
    run_idle(200);

    // reset mid-wait with a full queue
    push(50, 3'b001, 3'b111);
    push(50, 3'b010, 3'b111);
    push(50, 3'b011, 3'b111);
    push(50, 3'b100, 3'b111);
    run(5);
    #2;
    n_apply = 0;
    do_reset();
    run(120);
    chk("t1_no_apply", n_apply, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
